// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: arbitrates memory wait,
// taken-branch flush and load-use bubbles, and keeps stall/flush statistics.
module pipe_hazard_ctrl #(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 64,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       if_id_rn,
  input  logic [4:0]       if_id_rm,
  input  logic             if_id_uses_rm,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_mem_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             id_ex_bubble,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [1:0]       state_dbg
);

  // Handshake: the data memory owns the MEM stage while mem_req=1; an access
  // completes in the cycle mem_ready=1. Dropping mem_req also ends a wait.

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic [1:0]        LU_LAST   = 2'(LOAD_USE_CYCLES - 1);

  state_t            state, state_nxt;
  logic [1:0]        lu_cnt, lu_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              err_nxt;
  logic              count_flush;
  logic              luh;
  logic              freeze;

  assign state_dbg = state;

  // XZR reads as zero, so a load targeting it never feeds a consumer.
  assign luh = id_ex_mem_read && (id_ex_rd != 5'd31) &&
               ((id_ex_rd == if_id_rn) || (if_id_uses_rm && (id_ex_rd == if_id_rm)));

  assign freeze = mem_req && !mem_ready;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    id_ex_bubble = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    state_nxt    = state;
    lu_nxt       = lu_cnt;
    wait_nxt     = wait_cnt;
    err_nxt      = mem_err;
    count_flush  = 1'b0;

    if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      state_nxt    = MEM_WAIT;
      if (state != MEM_WAIT) begin
        wait_nxt = WAIT_W'(1);
      end else if (wait_cnt != WAIT_MAX) begin
        wait_nxt = wait_cnt + WAIT_W'(1);
      end
      if (wait_nxt >= TIMEOUT_V) begin
        err_nxt = 1'b1;
      end
    end else if (ex_mem_branch_taken) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      count_flush  = 1'b1;
      state_nxt    = RUN;
    end else if (state == LOAD_STALL) begin
      // Remaining bubbles of an earlier hazard; the consumer is still in IF/ID.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      lu_nxt       = lu_cnt + 2'd1;
      if (lu_cnt == LU_LAST) begin
        state_nxt = RUN;
      end
    end else if (luh) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (LOAD_USE_CYCLES > 1) begin
        state_nxt = LOAD_STALL;
        lu_nxt    = 2'd1;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      state_nxt = RUN;
    end

    if (!reset_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      id_ex_bubble = 1'b1;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      lu_cnt       <= 2'd0;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state    <= state_nxt;
      lu_cnt   <= lu_nxt;
      wait_cnt <= wait_nxt;
      mem_err  <= err_nxt;
      if (!pc_write && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (count_flush && (flush_events != '1)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three parameterisations driven in lockstep and
// compared every cycle against a behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

  localparam int N = 3;
  localparam logic [7:0] ADVANCE  = 8'b1111_0000;
  localparam logic [7:0] FREEZE   = 8'b0000_0000;
  localparam logic [7:0] BRANCH   = 8'b1111_0111;
  localparam logic [7:0] STALL    = 8'b0011_1000;
  localparam logic [7:0] RESET_OV = 8'b0000_1111;

  logic       clk;
  logic       reset_n;
  logic [4:0] rn, rm, rd;
  logic       uses_rm, mem_read, br, req, rdy;

  logic [7:0]  ctrl_o[N];
  logic        err_o[N];
  logic [15:0] stall_o[N];
  logic [15:0] flush_o[N];

  int luc_p[N]  = '{1, 2, 3};
  int tmo_p[N]  = '{64, 64, 5};
  int cmax_p[N] = '{65535, 65535, 15};

  int m_stall_left[N];
  int m_in_wait[N];
  int m_waited[N];
  int m_err[N];
  int m_stalls[N];
  int m_flushes[N];

  logic [31:0] exp_q[$];
  int n_checks;
  int n_pass;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = (g == 2) ? 4 : 16;
    logic [CW-1:0] sc, fe;
    logic [1:0]    st;
    logic          pw, iw, ew, mw, bb, f1, f2, f3, er;
    pipe_hazard_ctrl #(
      .LOAD_USE_CYCLES(g + 1),
      .MEM_TIMEOUT((g == 2) ? 5 : 64),
      .CNT_W(CW)
    ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .if_id_rn(rn),
      .if_id_rm(rm),
      .if_id_uses_rm(uses_rm),
      .id_ex_rd(rd),
      .id_ex_mem_read(mem_read),
      .ex_mem_branch_taken(br),
      .mem_req(req),
      .mem_ready(rdy),
      .pc_write(pw),
      .if_id_write(iw),
      .id_ex_write(ew),
      .ex_mem_write(mw),
      .id_ex_bubble(bb),
      .flush_if_id(f1),
      .flush_id_ex(f2),
      .flush_ex_mem(f3),
      .mem_err(er),
      .stall_cycles(sc),
      .flush_events(fe),
      .state_dbg(st)
    );
    assign ctrl_o[g]  = {pw, iw, ew, mw, bb, f1, f2, f3};
    assign err_o[g]   = er;
    assign stall_o[g] = 16'(sc);
    assign flush_o[g] = 16'(fe);
  end

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_stall_left[i] = 0;
      m_in_wait[i]    = 0;
      m_waited[i]     = 0;
      m_err[i]        = 0;
      m_stalls[i]     = 0;
      m_flushes[i]    = 0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_ctrl%0d", tag, i), 32'(ctrl_o[i]), 32'(RESET_OV));
      check($sformatf("%s_err%0d", tag, i), 32'(err_o[i]), 32'd0);
      check($sformatf("%s_stall%0d", tag, i), 32'(stall_o[i]), 32'd0);
      check($sformatf("%s_flush%0d", tag, i), 32'(flush_o[i]), 32'd0);
    end
  endtask

  // Reference model: outputs for the current cycle, then the post-edge state.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      logic [7:0] ctrl;
      bit luh;
      luh = mem_read && (rd != 5'd31) && ((rd == rn) || (uses_rm && (rd == rm)));
      exp_q.push_back(32'(m_err[i]));
      exp_q.push_back(32'(m_stalls[i]));
      exp_q.push_back(32'(m_flushes[i]));
      if (req && !rdy) begin
        ctrl = FREEZE;
        m_waited[i] = (m_in_wait[i] != 0) ? m_waited[i] + 1 : 1;
        m_in_wait[i] = 1;
        m_stall_left[i] = 0;
        if (m_waited[i] >= tmo_p[i]) m_err[i] = 1;
      end else begin
        m_in_wait[i] = 0;
        if (br) begin
          ctrl = BRANCH;
          m_stall_left[i] = 0;
          if (m_flushes[i] < cmax_p[i]) m_flushes[i]++;
        end else if (m_stall_left[i] > 0) begin
          ctrl = STALL;
          m_stall_left[i]--;
        end else if (luh) begin
          ctrl = STALL;
          m_stall_left[i] = luc_p[i] - 1;
        end else begin
          ctrl = ADVANCE;
        end
      end
      if (!ctrl[7] && (m_stalls[i] < cmax_p[i])) m_stalls[i]++;
      exp_q.push_back(32'(ctrl));
      check($sformatf("err%0d", i), 32'(err_o[i]), exp_q.pop_front());
      check($sformatf("stall_cycles%0d", i), 32'(stall_o[i]), exp_q.pop_front());
      check($sformatf("flush_events%0d", i), 32'(flush_o[i]), exp_q.pop_front());
      check($sformatf("ctrl%0d", i), 32'(ctrl_o[i]), exp_q.pop_front());
    end
  endtask

  // driver: called at a negedge, returns at the next negedge
  task automatic cycle(input logic [4:0] d, input logic m, input logic [4:0] n,
                       input logic [4:0] r, input logic u, input logic b,
                       input logic q, input logic y);
    rd = d; mem_read = m; rn = n; rm = r; uses_rm = u; br = b; req = q; rdy = y;
    #1;
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(5'd0, 1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [4:0] pick_reg();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 5'd31 : 5'(v);
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    rd = 5'd0; mem_read = 1'b0; rn = 5'd0; rm = 5'd0;
    uses_rm = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // load-use on Rn, then drain
    cycle(5'd5, 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // XZR exemption and Rm gating
    cycle(5'd31, 1'b1, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(5'd7, 1'b1, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(5'd7, 1'b1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    // branch colliding with load-use, then branch aborting a multi-cycle stall
    cycle(5'd5, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    cycle(5'd5, 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    // memory wait of three cycles, then one with a deferred branch
    repeat (3) cycle(5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) cycle(5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    // load-use on the release cycle of a wait
    cycle(5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(5'd3, 1'b1, 5'd3, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    // timeout: 64 waiting cycles, release, error stays sticky
    repeat (64) cycle(5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    // async reset pulse in the middle of a wait
    repeat (3) cycle(5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cycle(5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      cycle(pick_reg(), 1'($urandom_range(0, 1)), pick_reg(), pick_reg(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
